// File: rtl/ntsc_timing_pkg.sv
// Shared timing constants, counter widths, encoder levels and the
// registered output bundle for the tiny NTSC timing path.
package ntsc_timing_pkg;

    // Counter and coordinate widths
    localparam int unsigned H_W = 10;
    localparam int unsigned V_W = 9;
    localparam int unsigned X_W = 10;
    localparam int unsigned Y_W = 8;

    // Default 4fsc line/field timing
    localparam int unsigned DEF_H_TOTAL     = 910;
    localparam int unsigned DEF_H_SYNC      = 67;
    localparam int unsigned DEF_H_BURST_ST  = 76;
    localparam int unsigned DEF_H_BURST_LEN = 36;
    localparam int unsigned DEF_H_ACT_ST    = 160;
    localparam int unsigned DEF_H_ACT_LEN   = 640;
    localparam int unsigned DEF_V_TOTAL     = 262;
    localparam int unsigned DEF_V_SYNC_ST   = 3;
    localparam int unsigned DEF_V_SYNC_LEN  = 3;
    localparam int unsigned DEF_V_ACT_ST    = 20;
    localparam int unsigned DEF_V_ACT_LEN   = 240;

    // Encoder DAC levels (8-bit codes)
    localparam logic [7:0] LVL_SYNC_TIP  = 8'd0;
    localparam logic [7:0] LVL_BLANK     = 8'd60;
    localparam logic [7:0] LVL_PEDESTAL  = 8'd64;
    localparam logic [7:0] LVL_BURST_AMP = 8'd20;

    // Registered output bundle
    typedef struct packed {
        logic           xsync;
        logic           blank;
        logic           burst;
        logic           act;
        logic [X_W-1:0] xpos;
        logic [Y_W-1:0] ypos;
        logic           frame;
    } timing_t;

    localparam timing_t TIMING_RST = '{xsync: 1'b1, blank: 1'b1, default: '0};

    // Half-open window test: st <= x < st+len
    function automatic logic in_window(input int unsigned x,
                                       input int unsigned st,
                                       input int unsigned len);
        return (x >= st) && (x < st + len);
    endfunction

endpackage

// File: rtl/ntsc_hv_cnt.sv
// Enable-gated horizontal/vertical wrap counters; v steps when h wraps.
module ntsc_hv_cnt
    import ntsc_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL = DEF_H_TOTAL,
    parameter int unsigned V_TOTAL = DEF_V_TOTAL
) (
    input  logic           CK_i,
    input  logic           XAR_i,
    input  logic           CK_EE_i,
    output logic [H_W-1:0] H_o,
    output logic [V_W-1:0] V_o
);

    localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);

    logic [H_W-1:0] h_q, h_d;
    logic [V_W-1:0] v_q, v_d;

    // Next-count: h wraps at end of line, v advances on that wrap
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (CK_EE_i) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Counter registers, asynchronously cleared
    always_ff @(posedge CK_i or negedge XAR_i) begin
        if (!XAR_i) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign H_o = h_q;
    assign V_o = v_q;

endmodule

// File: rtl/ntsc_timing_gen.sv
// NTSC line/field timing generator: registered decode of the current
// (h,v) into sync, blanking, burst, active flag and pixel coordinates.
module ntsc_timing_gen
    import ntsc_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL     = DEF_H_TOTAL,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BURST_ST  = DEF_H_BURST_ST,
    parameter int unsigned H_BURST_LEN = DEF_H_BURST_LEN,
    parameter int unsigned H_ACT_ST    = DEF_H_ACT_ST,
    parameter int unsigned H_ACT_LEN   = DEF_H_ACT_LEN,
    parameter int unsigned V_TOTAL     = DEF_V_TOTAL,
    parameter int unsigned V_SYNC_ST   = DEF_V_SYNC_ST,
    parameter int unsigned V_SYNC_LEN  = DEF_V_SYNC_LEN,
    parameter int unsigned V_ACT_ST    = DEF_V_ACT_ST,
    parameter int unsigned V_ACT_LEN   = DEF_V_ACT_LEN
) (
    input  logic           CK_i,
    input  logic           XAR_i,
    input  logic           CK_EE_i,
    output logic           XSYNC_o,
    output logic           BLANK_o,
    output logic           BURST_o,
    output logic           ACT_o,
    output logic [X_W-1:0] XPOS_o,
    output logic [Y_W-1:0] YPOS_o,
    output logic           FRAME_o
);

    // Elaboration-time parameter legality
    if (H_ACT_ST + H_ACT_LEN > H_TOTAL) begin : g_bad_hact
        $error("ntsc_timing_gen: active window exceeds H_TOTAL");
    end
    if (H_BURST_ST + H_BURST_LEN > H_ACT_ST) begin : g_bad_burst
        $error("ntsc_timing_gen: burst overlaps active window");
    end
    if (V_ACT_ST + V_ACT_LEN > V_TOTAL) begin : g_bad_vact
        $error("ntsc_timing_gen: active lines exceed V_TOTAL");
    end
    if (V_SYNC_ST + V_SYNC_LEN > V_ACT_ST) begin : g_bad_vsync
        $error("ntsc_timing_gen: vsync overlaps active lines");
    end
    if (H_TOTAL > (1 << H_W) || V_TOTAL > (1 << V_W) || H_SYNC >= H_TOTAL) begin : g_bad_tot
        $error("ntsc_timing_gen: totals do not fit counter widths");
    end
    if (H_ACT_LEN > (1 << X_W) || V_ACT_LEN > (1 << Y_W)) begin : g_bad_pos
        $error("ntsc_timing_gen: active size does not fit coordinate widths");
    end

    logic [H_W-1:0] h;
    logic [V_W-1:0] v;

    ntsc_hv_cnt #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_hv_cnt (
        .CK_i    (CK_i),
        .XAR_i   (XAR_i),
        .CK_EE_i (CK_EE_i),
        .H_o     (h),
        .V_o     (v)
    );

    timing_t timing_q, timing_d;
    logic    vs, sync_low, hact, vact, act, burst;

    // Decode the pre-increment (h,v); loaded only on enabled cycles
    always_comb begin
        vs       = in_window(32'(v), V_SYNC_ST, V_SYNC_LEN);
        // vsync lines use an inverted broad pulse: low for all but the last H_SYNC slots
        sync_low = vs ? (32'(h) < H_TOTAL - H_SYNC) : (32'(h) < H_SYNC);
        burst    = !vs && in_window(32'(h), H_BURST_ST, H_BURST_LEN);
        hact     = in_window(32'(h), H_ACT_ST, H_ACT_LEN);
        vact     = in_window(32'(v), V_ACT_ST, V_ACT_LEN);
        act      = hact && vact;

        timing_d = timing_q;
        if (CK_EE_i) begin
            timing_d.xsync = !sync_low;
            timing_d.burst = burst;
            timing_d.act   = act;
            timing_d.blank = !act;
            timing_d.xpos  = act ? X_W'(32'(h) - H_ACT_ST) : '0;
            timing_d.ypos  = act ? Y_W'(32'(v) - V_ACT_ST) : '0;
            timing_d.frame = (h == '0) && (v == '0);
        end
    end

    // Output register bank, asynchronously returned to idle levels
    always_ff @(posedge CK_i or negedge XAR_i) begin
        if (!XAR_i) begin
            timing_q <= TIMING_RST;
        end else begin
            timing_q <= timing_d;
        end
    end

    assign XSYNC_o = timing_q.xsync;
    assign BLANK_o = timing_q.blank;
    assign BURST_o = timing_q.burst;
    assign ACT_o   = timing_q.act;
    assign XPOS_o  = timing_q.xpos;
    assign YPOS_o  = timing_q.ypos;
    assign FRAME_o = timing_q.frame;

endmodule
